dich_checker: RTL and testbench
===============================

DICH_CHECKER -- requirements
Module: dich_checker

Interface
REQ-001 SHALL have parameter STALL_LIM, default 1000, meaning cycles without an LED change before a stall is flagged (legal range 2..65535).
REQ-002 SHALL have parameter DIR, default 0, meaning expected shift direction: 0 = left (0x01->0x02->...->0x80->0x01), 1 = right (0x80->0x40->...->0x01->0x80).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port led_in, input, 8, meaning the observed LED pattern from the walking-one shifter.
REQ-006 SHALL have port locked, output, 1, meaning checker is tracking a valid walking-one sequence.
REQ-007 SHALL have port pos, output, 3, meaning bit index of the lit LED while locked.
REQ-008 SHALL have port err, output, 1, meaning one-cycle pulse on a sequence violation.
REQ-009 SHALL have port stall, output, 1, meaning one-cycle pulse on a stall timeout.
REQ-010 SHALL have port err_count, output, 8, meaning violations plus stalls since reset, saturating.
REQ-011 SHALL have port step_count, output, 16, meaning correct steps since reset, wrapping.

Function
REQ-012 SHALL register led_in once into led_q and keep the previous value in led_p; a change event is led_q != led_p.
REQ-013 SHALL implement states IDLE, LOCKED.
REQ-014 In IDLE, on a change event with led_q one-hot, SHALL go to LOCKED, set pos to the index of the set bit, and leave step_count unchanged.
REQ-015 In IDLE, a change event with led_q not one-hot (including 0x00) SHALL be ignored: no err pulse and no count change.
REQ-016 In LOCKED, expected = pos+1 mod 8 (DIR=0) or pos-1 mod 8 (DIR=1); wrap 7->0 and 0->7 is legal.
REQ-017 In LOCKED, on a change event with led_q == one-hot(expected), SHALL update pos, increment step_count (wrap 0xFFFF->0), and clear the stall counter.
REQ-018 In LOCKED, on a change event with any other value, SHALL pulse err for one cycle, increment err_count, and go to IDLE with locked=0.
REQ-019 In LOCKED, each cycle without a change event SHALL increment the stall counter; when it reaches STALL_LIM-1, SHALL pulse stall, increment err_count, clear the counter, and go to IDLE.
REQ-020 A change event SHALL always take priority over a stall in the same cycle, so err and stall are never both asserted.
REQ-021 err_count SHALL saturate at 255.
REQ-022 Latency: a led_in value present before rising edge N SHALL be reflected in locked, pos, err and step_count after edge N+1.
REQ-023 The stall counter SHALL be held at 0 while in IDLE.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 With rst=1 at a rising edge, the block SHALL enter IDLE with locked=0, pos=0, err=0, stall=0, err_count=0, step_count=0, stall counter=0, and led_q=led_p=0x00.
REQ-026 Reset asserted mid-sequence SHALL take precedence over every event in that cycle.
REQ-027 After reset, the first non-zero one-hot value SHALL be treated as a change event.

Verification
REQ-028 Reset, then step led_in 0x01,0x02,...,0x80,0x01, holding each value 5 cycles -> locked=1 two cycles after 0x01, step_count=8, err_count=0, pos=0 at the end.
REQ-029 While locked at 0x04, drive 0x10 -> err is high for exactly 1 cycle, err_count=1, locked=0; then 0x20 -> relocks with pos=5 and step_count unchanged.
REQ-030 Lock at 0x08, then hold it for STALL_LIM cycles -> stall pulses once, err_count=1, locked=0, and no further stall pulse while held.
REQ-031 In IDLE, drive 0x03, 0x00, 0xFF -> locked stays 0, err never pulses, err_count=0.
REQ-032 Force 300 violations -> err_count=255 and holds; assert rst mid-sequence -> all outputs read 0 on the next cycle.
REQ-033 DIR=1, drive 0x01 then 0x80 -> legal wrap: step_count=1, err=0, pos=7.

Source files
------------

// File: rtl/dich_checker.sv
// Walking-one LED checker: locks onto a one-hot shift sequence, counts legal steps,
// flags out-of-order patterns and stalls.
module dich_checker #(
  parameter int unsigned STALL_LIM = 1000,
  parameter bit          DIR       = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  led_in,
  output logic        locked,
  output logic [2:0]  pos,
  output logic        err,
  output logic        stall,
  output logic [7:0]  err_count,
  output logic [15:0] step_count
);

  localparam int unsigned LED_W  = 8;
  localparam int unsigned POS_W  = 3;
  localparam int unsigned ERR_W  = 8;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [LED_W-1:0]   led_q, led_p;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [POS_W-1:0]   pos_d, exp_pos, hot_idx;
  logic [LED_W-1:0]   exp_led;
  logic               err_d, stall_d, locked_d;
  logic [ERR_W-1:0]   err_count_d;
  logic [STEP_W-1:0]  step_count_d;
  logic               change, onehot;
  logic               lock_ev, step_ev, viol_ev, stall_ev;

  function automatic logic [POS_W-1:0] bit_index(input logic [LED_W-1:0] v);
    logic [POS_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(LED_W); i++) begin
      if (v[i]) idx = POS_W'(i);
    end
    return idx;
  endfunction

  assign change  = (led_q != led_p);
  assign onehot  = $onehot(led_q);
  assign hot_idx = bit_index(led_q);
  assign exp_pos = DIR ? (pos - POS_W'(1)) : (pos + POS_W'(1));
  assign exp_led = LED_W'(1) << exp_pos;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and event decode; a change event always wins over a stall
  always_comb begin
    state_d  = state_q;
    lock_ev  = 1'b0;
    step_ev  = 1'b0;
    viol_ev  = 1'b0;
    stall_ev = 1'b0;
    case (state_q)
      IDLE: begin
        if (change && onehot) begin
          state_d = LOCKED;
          lock_ev = 1'b1;
        end
      end
      LOCKED: begin
        if (change) begin
          if (led_q == exp_led) begin
            step_ev = 1'b1;
          end else begin
            viol_ev = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_inc == CNT_W'(STALL_LIM - 1)) begin
          stall_ev = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the stall counter
  always_comb begin
    pos_d        = pos;
    err_d        = viol_ev;
    stall_d      = stall_ev;
    locked_d     = (state_d == LOCKED);
    step_count_d = step_count + STEP_W'(step_ev);
    err_count_d  = err_count;
    cnt_d        = '0;
    if (lock_ev) pos_d = hot_idx;
    if (step_ev) pos_d = exp_pos;
    if ((viol_ev || stall_ev) && (err_count != {ERR_W{1'b1}}))
      err_count_d = err_count + ERR_W'(1);
    if ((state_q == LOCKED) && !change && !stall_ev)
      cnt_d = cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      led_p      <= '0;
      cnt_q      <= '0;
      locked     <= 1'b0;
      pos        <= '0;
      err        <= 1'b0;
      stall      <= 1'b0;
      err_count  <= '0;
      step_count <= '0;
    end else begin
      led_q      <= led_in;
      led_p      <= led_q;
      cnt_q      <= cnt_d;
      locked     <= locked_d;
      pos        <= pos_d;
      err        <= err_d;
      stall      <= stall_d;
      err_count  <= err_count_d;
      step_count <= step_count_d;
    end
  end

endmodule

// File: tb/tb_dich_checker.sv
// Bench for dich_checker: hand-written vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the checker rules.
module tb_dich_checker;

  localparam int unsigned SL = 20;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic [7:0]  led, led1;
  logic        locked, err, stall, locked1, err1, stall1;
  logic [2:0]  pos, pos1;
  logic [7:0]  err_count, err_count1;
  logic [15:0] step_count, step_count1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dich_checker #(.STALL_LIM(SL), .DIR(1'b0)) dut (
    .clk(clk), .rst(rst), .led_in(led), .locked(locked), .pos(pos), .err(err),
    .stall(stall), .err_count(err_count), .step_count(step_count));

  dich_checker #(.STALL_LIM(SL), .DIR(1'b1)) dut_r (
    .clk(clk), .rst(rst1), .led_in(led1), .locked(locked1), .pos(pos1), .err(err1),
    .stall(stall1), .err_count(err_count1), .step_count(step_count1));

  // Behavioural model of the left-shifting checker
  logic [7:0] m_q, m_p;
  bit m_lock, m_err, m_stall;
  int m_pos, m_errc, m_step, m_quiet;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input logic [7:0] v, input bit r);
    if (r) begin
      m_q = 0; m_p = 0; m_lock = 0; m_err = 0; m_stall = 0;
      m_pos = 0; m_errc = 0; m_step = 0; m_quiet = 0;
      return;
    end
    m_err = 0; m_stall = 0;
    if (m_q != m_p) begin
      m_quiet = 0;
      if (!m_lock) begin
        if ($countones(m_q) == 1) begin m_lock = 1; m_pos = idx_of(m_q); end
      end else if (idx_of(m_q) == (m_pos + 1) % 8 && $countones(m_q) == 1) begin
        m_pos = (m_pos + 1) % 8;
        m_step = (m_step + 1) % 65536;
      end else begin
        m_err = 1; m_lock = 0;
        m_errc = (m_errc < 255) ? m_errc + 1 : 255;
      end
    end else if (m_lock) begin
      m_quiet++;
      if (m_quiet == SL - 1) begin
        m_stall = 1; m_lock = 0; m_quiet = 0;
        m_errc = (m_errc < 255) ? m_errc + 1 : 255;
      end
    end
    m_p = m_q;
    m_q = v;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare just after
  task automatic cycle(input logic [7:0] v, input bit r);
    @(negedge clk);
    led = v; rst = r;
    @(posedge clk);
    model_step(v, r);
    #1;
    chk("model_locked", int'(locked), int'(m_lock));
    chk("model_err", int'(err), int'(m_err));
    chk("model_stall", int'(stall), int'(m_stall));
    chk("model_err_count", int'(err_count), m_errc);
    chk("model_step_count", int'(step_count), m_step);
    if (m_lock) chk("model_pos", int'(pos), m_pos);
  endtask

  task automatic cycle_r(input logic [7:0] v, input bit r);
    @(negedge clk);
    led1 = v; rst1 = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] led;
    bit         locked;
    int         pos;
    bit         err;
    int         errc;
    int         step;
  } vec_t;

  vec_t tbl[14];
  logic [7:0] cur, v;
  int cnt, rr;

  initial begin
    tbl[0]  = '{8'h01, 0, 0, 0, 0, 0};
    tbl[1]  = '{8'h01, 1, 0, 0, 0, 0};
    tbl[2]  = '{8'h02, 1, 0, 0, 0, 0};
    tbl[3]  = '{8'h02, 1, 1, 0, 0, 1};
    tbl[4]  = '{8'h08, 1, 1, 0, 0, 1};
    tbl[5]  = '{8'h08, 0, 0, 1, 1, 1};
    tbl[6]  = '{8'h08, 0, 0, 0, 1, 1};
    tbl[7]  = '{8'h03, 0, 0, 0, 1, 1};
    tbl[8]  = '{8'h00, 0, 0, 0, 1, 1};
    tbl[9]  = '{8'hFF, 0, 0, 0, 1, 1};
    tbl[10] = '{8'h20, 0, 0, 0, 1, 1};
    tbl[11] = '{8'h20, 1, 5, 0, 1, 1};
    tbl[12] = '{8'h40, 1, 5, 0, 1, 1};
    tbl[13] = '{8'h40, 1, 6, 0, 1, 2};

    led = 0; rst = 1; led1 = 0; rst1 = 1;
    cycle(8'h00, 1); cycle(8'h00, 1);
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("reset_step_count", int'(step_count), 0);

    // Hand-computed vector table
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].led, 0);
      chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].locked));
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].err));
      chk($sformatf("tbl%0d_err_count", i), int'(err_count), tbl[i].errc);
      chk($sformatf("tbl%0d_step_count", i), int'(step_count), tbl[i].step);
      if (tbl[i].locked) chk($sformatf("tbl%0d_pos", i), int'(pos), tbl[i].pos);
    end

    // Full walk 0x01..0x80,0x01 holding 5 cycles each
    cycle(8'h00, 1);
    for (int k = 0; k < 9; k++) begin
      cur = 8'h01 << (k % 8);
      for (int h = 0; h < 5; h++) begin
        cycle(cur, 0);
        if (k == 0 && h == 0) chk("walk_lock_latency0", int'(locked), 0);
        if (k == 0 && h == 1) chk("walk_lock_latency1", int'(locked), 1);
      end
    end
    chk("walk_step_count", int'(step_count), 8);
    chk("walk_err_count", int'(err_count), 0);
    chk("walk_pos", int'(pos), 0);

    // Violation from 0x04 to 0x10, then relock on 0x20
    cycle(8'h00, 1);
    cnt = 0;
    cycle(8'h04, 0); cycle(8'h04, 0);
    chk("viol_locked_at4", int'(locked), 1);
    chk("viol_pos4", int'(pos), 2);
    for (int h = 0; h < 4; h++) begin cycle(8'h10, 0); cnt += int'(err); end
    chk("viol_err_pulses", cnt, 1);
    chk("viol_err_count", int'(err_count), 1);
    chk("viol_locked", int'(locked), 0);
    cycle(8'h20, 0); cycle(8'h20, 0);
    chk("relock_locked", int'(locked), 1);
    chk("relock_pos", int'(pos), 5);
    chk("relock_step_count", int'(step_count), 0);

    // Stall: lock at 0x08 and hold well beyond the limit
    cycle(8'h00, 1);
    cnt = 0;
    for (int h = 0; h < int'(SL) + 30; h++) begin cycle(8'h08, 0); cnt += int'(stall); end
    chk("stall_pulses", cnt, 1);
    chk("stall_err_count", int'(err_count), 1);
    chk("stall_locked", int'(locked), 0);

    // 300 violations saturate err_count, then reset mid-sequence
    cycle(8'h00, 1);
    for (int n = 0; n < 300; n++) begin cycle(8'h01, 0); cycle(8'h04, 0); end
    chk("sat_err_count", int'(err_count), 255);
    cycle(8'h01, 0); cycle(8'h04, 0); cycle(8'h01, 0);
    chk("sat_hold", int'(err_count), 255);
    cycle(8'h04, 1);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_pos", int'(pos), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_err_count", int'(err_count), 0);
    chk("midrst_step_count", int'(step_count), 0);

    // Right-shift instance: 0x01 -> 0x80 is a legal wrap, then 0x40
    cnt = 0;
    cycle_r(8'h00, 1);
    cycle_r(8'h01, 0); cycle_r(8'h01, 0);
    chk("dir1_lock_pos", int'(pos1), 0);
    for (int h = 0; h < 3; h++) begin cycle_r(8'h80, 0); cnt += int'(err1); end
    chk("dir1_err_pulses", cnt, 0);
    chk("dir1_step_count", int'(step_count1), 1);
    chk("dir1_pos", int'(pos1), 7);
    chk("dir1_locked", int'(locked1), 1);
    cycle_r(8'h40, 0); cycle_r(8'h40, 0);
    chk("dir1_step2", int'(step_count1), 2);
    cycle_r(8'h80, 0); cycle_r(8'h80, 0);
    chk("dir1_back_err", int'(err1), 1);
    chk("dir1_back_err_count", int'(err_count1), 1);

    // Randomized traffic against the model
    cycle(8'h00, 1);
    cur = 8'h01;
    for (int n = 0; n < 4000; n++) begin
      rr = int'($urandom_range(0, 99));
      if (rr < 50) cur = {cur[6:0], cur[7]};
      else if (rr < 70) cur = cur;
      else if (rr < 80) cur = 8'h01 << $urandom_range(0, 7);
      else if (rr < 93) begin v = 8'($urandom); cur = v; end
      else if (rr < 96) begin
        for (int h = 0; h < int'(SL) + 3; h++) cycle(cur, 0);
      end
      if (rr == 99) cycle(cur, 1);
      else cycle(cur, 0);
      if ($countones(cur) != 1 && rr < 50) cur = 8'h01;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
